spike_delay_line: RTL and testbench

Parametrised multi-channel spike delay line. NCH one-bit spike channels are written every sample tick into a circular buffer and read back exactly D ticks later. D is runtime-programmable, clamped to the buffer depth, and its changes are guarded by a fill phase so stale buffer contents are never emitted. Sits between spike generators (neuron/spindle models) and downstream synapse/integrator blocks, modelling axonal conduction delay.

---
 rtl/spike_delay_pkg.sv | 35 +++
 rtl/spike_ring_ram.sv | 29 ++
 rtl/spike_delay_line.sv | 165 ++++++++++++++++
 tb/tb_spike_delay_line.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spike_delay_pkg.sv
// Shared types and helpers for the spike delay line: FSM states, delay clamp,
// channel popcount and the spike counter width.
package spike_delay_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_W   = 32;
  localparam int MAX_NCH = 256;

  // Delay 0 is meaningless (read would hit the write slot), so it becomes 1.
  function automatic logic [31:0] clamp_delay(input logic [31:0] req, input logic [31:0] depth);
    logic [31:0] res;
    if (req == 32'd0) begin
      res = 32'd1;
    end else if (req >= depth) begin
      res = depth - 32'd1;
    end else begin
      res = req;
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_NCH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/spike_ring_ram.sv
// Simple dual-port ring buffer storage: one write port, one synchronous read
// port, single clock. Contents are deliberately not reset so it maps to block RAM.
module spike_ring_ram #(
  parameter int NCH   = 1,
  parameter int DEPTH = 100,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           i_clk1,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [NCH-1:0] i_din,
  input  logic           i_re,
  input  logic [AW-1:0]  i_raddr,
  output logic [NCH-1:0] o_dout
);

  logic [NCH-1:0] r_mem [DEPTH];

  // Write and registered read share the tick edge; addresses never collide.
  always_ff @(posedge i_clk1) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_din;
    end
    if (i_re) begin
      o_dout <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/spike_delay_line.sv
// Multi-channel spike delay line: spikes are written each tick and replayed D
// ticks later. Optional spike counter enabled by macro SPIKE_DELAY_CNT_EN.
module spike_delay_line
  import spike_delay_pkg::*;
#(
  parameter int NCH           = 1,
  parameter int DEPTH         = 100,
  parameter int DEFAULT_DELAY = 5,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic             i_clk1,
  input  logic             i_reset,
  input  logic             i_sample_en,
  input  logic [NCH-1:0]   i_spike_in,
  input  logic             i_delay_ld,
  input  logic [AW-1:0]    i_delay_in,
  output logic [NCH-1:0]   o_spike_out,
  output logic             o_filled,
  output logic             o_delay_clamped
`ifdef SPIKE_DELAY_CNT_EN
  ,
  output logic [CNT_W-1:0] o_spike_cnt
`endif
);

  state_e         r_state;
  state_e         w_next_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_fill_cnt;
  logic [AW-1:0]  r_delay;
  logic           r_valid;
  logic           r_clamped;
  logic [AW-1:0]  w_fill_cnt_nxt;
  logic           w_valid_nxt;
  logic [AW-1:0]  w_wr_ptr_nxt;
  logic [AW-1:0]  w_rd_addr;
  logic [AW-1:0]  w_delay_new;
  logic           w_clamp_hit;
  logic           w_fill_done;
  logic [NCH-1:0] w_ram_dout;

  assign w_delay_new  = AW'(clamp_delay(32'(i_delay_in), 32'(DEPTH)));
  assign w_clamp_hit  = (i_delay_in == '0) || (32'(i_delay_in) >= 32'(DEPTH));
  assign w_fill_done  = (r_fill_cnt == (r_delay - AW'(1)));
  assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : (r_wr_ptr + AW'(1));
  // Modular subtraction; the intermediate may wrap in AW bits but the result is < DEPTH.
  assign w_rd_addr    = (r_wr_ptr < r_delay) ? (r_wr_ptr + AW'(DEPTH) - r_delay)
                                             : (r_wr_ptr - r_delay);

  spike_ring_ram #(
    .NCH  (NCH),
    .DEPTH(DEPTH)
  ) u_ram (
    .i_clk1 (i_clk1),
    .i_we   (i_sample_en),
    .i_waddr(r_wr_ptr),
    .i_din  (i_spike_in),
    .i_re   (i_sample_en),
    .i_raddr(w_rd_addr),
    .o_dout (w_ram_dout)
  );

  always_ff @(posedge i_clk1 or posedge i_reset) begin
    if (i_reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_delay_ld) begin
      w_next_state = FILL;
    end else if (i_sample_en) begin
      case (r_state)
        FILL:    w_next_state = w_fill_done ? RUN : FILL;
        RUN:     w_next_state = RUN;
        default: w_next_state = FILL;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // A tick that coincides with a delay load is written but not counted toward fill.
  always_comb begin
    w_fill_cnt_nxt = r_fill_cnt;
    w_valid_nxt    = r_valid;
    if (i_delay_ld) begin
      w_fill_cnt_nxt = '0;
      w_valid_nxt    = 1'b0;
    end else if (i_sample_en) begin
      case (r_state)
        FILL: begin
          w_fill_cnt_nxt = w_fill_done ? '0 : (r_fill_cnt + AW'(1));
          w_valid_nxt    = 1'b0;
        end
        RUN: begin
          w_fill_cnt_nxt = '0;
          w_valid_nxt    = 1'b1;
        end
        default: begin
          w_fill_cnt_nxt = '0;
          w_valid_nxt    = 1'b0;
        end
      endcase
    end else begin
      w_fill_cnt_nxt = r_fill_cnt;
      w_valid_nxt    = r_valid;
    end
  end

  always_ff @(posedge i_clk1 or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_delay    <= AW'(DEFAULT_DELAY);
      r_valid    <= 1'b0;
      r_clamped  <= 1'b0;
    end else begin
      r_fill_cnt <= w_fill_cnt_nxt;
      r_valid    <= w_valid_nxt;
      if (i_sample_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (i_delay_ld) begin
        r_delay   <= w_delay_new;
        r_clamped <= w_clamp_hit;
      end
    end
  end

  // RAM data only moves on ticks; r_valid masks stale contents during fill.
  assign o_spike_out     = w_ram_dout & {NCH{r_valid}};
  assign o_filled        = r_valid;
  assign o_delay_clamped = r_clamped;

`ifdef SPIKE_DELAY_CNT_EN
  logic               r_cnt_pend;
  logic [CNT_W-1:0]   r_spike_cnt;
  logic [CNT_W:0]     w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_spike_cnt} + {1'b0, popcount(MAX_NCH'(o_spike_out))};

  // Emitted word is only visible the cycle after its RUN tick, so accumulate one clock late.
  always_ff @(posedge i_clk1 or posedge i_reset) begin
    if (i_reset) begin
      r_cnt_pend  <= 1'b0;
      r_spike_cnt <= '0;
    end else if (i_delay_ld) begin
      r_cnt_pend  <= 1'b0;
      r_spike_cnt <= '0;
    end else begin
      r_cnt_pend <= i_sample_en && (r_state == RUN);
      if (r_cnt_pend) begin
        r_spike_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign o_spike_cnt = r_spike_cnt;
`endif

endmodule

// File: tb/tb_spike_delay_line.sv
// Scoreboard bench for spike_delay_line: stimulus queues expected words, a
// negedge monitor pops them whenever the DUT presents a valid delayed output.
module tb_spike_delay_line;

  localparam int NCH   = 4;
  localparam int DEPTH = 100;
  localparam int DEF_D = 5;
  localparam int AW    = 7;

  logic           clk1 = 1'b0;
  logic           reset = 1'b1;
  logic           sample_en = 1'b0;
  logic [NCH-1:0] spike_in = '0;
  logic           delay_ld = 1'b0;
  logic [AW-1:0]  delay_in = '0;
  logic [NCH-1:0] spike_out;
  logic           filled;
  logic           delay_clamped;
`ifdef SPIKE_DELAY_CNT_EN
  logic [31:0]    spike_cnt;
`endif

  int             total = 0;
  int             bad = 0;
  logic [NCH-1:0] exp_q[$];
  int             exp_d = DEF_D;
  logic           exp_clamped = 1'b0;
  int             tick_idx = 0;
  logic [NCH-1:0] last_out = '0;
  logic           last_filled = 1'b0;

  always #5 clk1 = ~clk1;

  spike_delay_line #(
    .NCH(NCH), .DEPTH(DEPTH), .DEFAULT_DELAY(DEF_D)
  ) dut (
    .i_clk1         (clk1),
    .i_reset        (reset),
    .i_sample_en    (sample_en),
    .i_spike_in     (spike_in),
    .i_delay_ld     (delay_ld),
    .i_delay_in     (delay_in),
    .o_spike_out    (spike_out),
    .o_filled       (filled),
    .o_delay_clamped(delay_clamped)
`ifdef SPIKE_DELAY_CNT_EN
    ,
    .o_spike_cnt    (spike_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are driven at negedge+1, so at negedge they still show what the last posedge sampled.
  always @(negedge clk1) begin
    logic [NCH-1:0] e;
    check("delay_clamped", 32'(delay_clamped), 32'(exp_clamped));
    if (reset) begin
      check("reset_out", 32'(spike_out), 32'd0);
      check("reset_filled", 32'(filled), 32'd0);
      tick_idx = 0;
      last_out = '0;
      last_filled = 1'b0;
    end else if (delay_ld) begin
      check("ld_out", 32'(spike_out), 32'd0);
      check("ld_filled", 32'(filled), 32'd0);
      tick_idx = 0;
      last_out = '0;
      last_filled = 1'b0;
    end else if (sample_en) begin
      tick_idx++;
      check("filled", 32'(filled), 32'(tick_idx > exp_d));
      if (tick_idx > exp_d) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got output %0h expected none queued", spike_out);
        end else begin
          e = exp_q.pop_front();
          check("spike_out", 32'(spike_out), 32'(e));
        end
      end else begin
        check("fill_out", 32'(spike_out), 32'd0);
      end
      last_out = spike_out;
      last_filled = filled;
    end else begin
      check("hold_out", 32'(spike_out), 32'(last_out));
      check("hold_filled", 32'(filled), 32'(last_filled));
    end
  end

  task automatic step(input logic en, input logic [NCH-1:0] s);
    @(negedge clk1);
    #1;
    reset = 1'b0;
    delay_ld = 1'b0;
    sample_en = en;
    spike_in = s;
    if (en) exp_q.push_back(s);
  endtask

  task automatic load(input logic [AW-1:0] din, input int d, input logic cl,
                      input logic en, input logic [NCH-1:0] s);
    @(negedge clk1);
    #1;
    reset = 1'b0;
    delay_ld = 1'b1;
    delay_in = din;
    sample_en = en;
    spike_in = s;
    exp_q.delete();
    exp_d = d;
    exp_clamped = cl;
  endtask

  task automatic pulse_reset();
    @(negedge clk1);
    #1;
    reset = 1'b1;
    delay_ld = 1'b0;
    sample_en = 1'b0;
    spike_in = '0;
    exp_q.delete();
    exp_d = DEF_D;
    exp_clamped = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk1);

    // Default delay 5: single ch0 spike at tick 10 emerges at tick 15.
    for (int i = 0; i < 20; i++) step(1'b1, (i == 10) ? 4'b0001 : 4'b0000);

    // Delay 20 with two patterns at ticks 3 and 4.
    load(7'd20, 20, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 30; i++)
      step(1'b1, (i == 3) ? 4'b1010 : ((i == 4) ? 4'b0101 : 4'b0000));

    // Clamp cases.
    load(7'd0, 1, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 1));
    load(7'd100, 99, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1001);
    load(7'd127, 99, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0110);
    load(7'd50, 50, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1100);

    // Sparse ticks, D=3; load coincides with a tick that must never be emitted.
    load(7'd3, 3, 1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i == 2) ? 4'b0011 : 4'b0000);
      repeat (3) step(1'b0, 4'b1111);
    end

    // Maximum delay across many pointer wraps.
    load(7'd99, 99, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 1000; i++) step(1'b1, 4'(i * 7 + 3));

    // Reset with spikes in flight; only fresh zeros may come out afterwards.
    pulse_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 4'b0000);

`ifdef SPIKE_DELAY_CNT_EN
    load(7'd5, 5, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000);
    repeat (3) step(1'b0, 4'b0000);
    @(negedge clk1);
    check("spike_cnt", spike_cnt, 32'd7);
    load(7'd5, 5, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    @(negedge clk1);
    check("spike_cnt_clear", spike_cnt, 32'd0);
`endif

    repeat (3) step(1'b0, 4'b0000);
    @(negedge clk1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
